// File: rtl/garegga_colmix.sv
// garegga_colmix -- final colour stage of the Garegga video path.
//
// On each accepted pixel enable the winning 11-bit palette index (text over GP9001 over
// backdrop 0) is registered onto the palette RAM address. The RAM word returns one cycle
// later, is captured, expanded from xBGR555 to 24-bit RGB and scaled by a brightness
// value latched once per frame. The result is driven three cycles after acceptance.
//
// Ports:
//   CLK96, RESET96          clock, asynchronous active-high reset
//   PIXEL_CEN               one-cycle pixel enable
//   HB, VB                  blanks aligned with the pixel inputs
//   TEXT_PIXEL, GP_PIXEL    candidate palette indices ([3:0]==0 is transparent)
//   BRIGHT                  brightness 0..16 (larger values clamp to 16)
//   PAL_ADDR / PAL_DATA     palette RAM read port (registered read, 1-cycle latency)
//   RED, GREEN, BLUE        output colour
//   HB_OUT, VB_OUT          blanks aligned with the colour outputs
//   PIX_VALID               one-cycle strobe when the colour outputs update
//   OVERRUN                 sticky: a pixel arrived before the previous read finished
module garegga_colmix #(
   parameter int unsigned PAL_AW = 11
) (
   input  logic              CLK96,
   input  logic              RESET96,
   input  logic              PIXEL_CEN,
   input  logic              HB,
   input  logic              VB,
   input  logic [10:0]       TEXT_PIXEL,
   input  logic [10:0]       GP_PIXEL,
   input  logic [4:0]        BRIGHT,
   output logic [PAL_AW-1:0] PAL_ADDR,
   input  logic [15:0]       PAL_DATA,
   output logic [7:0]        RED,
   output logic [7:0]        GREEN,
   output logic [7:0]        BLUE,
   output logic              HB_OUT,
   output logic              VB_OUT,
   output logic              PIX_VALID,
   output logic              OVERRUN
);

   typedef enum logic [1:0] {StIdle, StAddr, StWait, StCapt} state_e;

   state_e            state_q, state_d;
   logic [PAL_AW-1:0] pal_addr_q, pal_addr_d;
   logic              hb_lat_q, hb_lat_d;
   logic              vb_lat_q, vb_lat_d;
   logic [14:0]       pal_q, pal_d;
   logic [4:0]        b_lat_q, b_lat_d;
   logic              last_vb_q;
   logic [7:0]        red_q, red_d;
   logic [7:0]        green_q, green_d;
   logic [7:0]        blue_q, blue_d;
   logic              hb_out_q, hb_out_d;
   logic              vb_out_q, vb_out_d;
   logic              pix_valid_q, pix_valid_d;
   logic              overrun_q, overrun_d;

   logic [10:0]       sel_idx;
   logic [4:0]        bright_clamped;
   logic              accept;

   // Bit 15 of the palette word is not part of xBGR555.
   logic unused_pal_msb;
   assign unused_pal_msb = PAL_DATA[15];

   // Expand 5-bit channel to 8 bits and scale by b/16. The largest product (255*16) fits
   // in 12 bits, so bits [11:4] are the full scaled result.
   function automatic logic [7:0] scale(input logic [4:0] c5, input logic [4:0] b);
      logic [7:0]  c8;
      logic [11:0] prod;
      c8   = {c5, c5[4:2]};
      prod = {4'd0, c8} * {7'd0, b};
      return prod[11:4];
   endfunction

   always_comb begin
      if (TEXT_PIXEL[3:0] != 4'd0) begin
         sel_idx = TEXT_PIXEL;
      end else if (GP_PIXEL[3:0] != 4'd0) begin
         sel_idx = GP_PIXEL;
      end else begin
         sel_idx = 11'd0;
      end
   end

   assign bright_clamped = (BRIGHT > 5'd16) ? 5'd16 : BRIGHT;

   // Brightness only changes on the VB rising edge, i.e. once per frame.
   always_comb begin
      b_lat_d = b_lat_q;
      if (VB && !last_vb_q) begin
         b_lat_d = bright_clamped;
      end
   end

   always_comb begin
      state_d     = state_q;
      pal_addr_d  = pal_addr_q;
      hb_lat_d    = hb_lat_q;
      vb_lat_d    = vb_lat_q;
      pal_d       = pal_q;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
      hb_out_d    = hb_out_q;
      vb_out_d    = vb_out_q;
      pix_valid_d = 1'b0;
      overrun_d   = overrun_q;
      accept      = 1'b0;

      unique case (state_q)
         StIdle: begin
            accept = PIXEL_CEN;
         end
         StAddr: begin
            if (PIXEL_CEN) begin
               accept    = 1'b1;
               overrun_d = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (PIXEL_CEN) begin
               accept    = 1'b1;
               overrun_d = 1'b1;
            end else begin
               pal_d   = PAL_DATA[14:0];
               state_d = StCapt;
            end
         end
         StCapt: begin
            // Finishing pixel is always delivered; a new one may start in the same cycle.
            if (hb_lat_q || vb_lat_q) begin
               red_d   = 8'd0;
               green_d = 8'd0;
               blue_d  = 8'd0;
            end else begin
               red_d   = scale(pal_q[4:0], b_lat_q);
               green_d = scale(pal_q[9:5], b_lat_q);
               blue_d  = scale(pal_q[14:10], b_lat_q);
            end
            hb_out_d    = hb_lat_q;
            vb_out_d    = vb_lat_q;
            pix_valid_d = 1'b1;
            state_d     = StIdle;
            accept      = PIXEL_CEN;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (accept) begin
         pal_addr_d = sel_idx[PAL_AW-1:0];
         hb_lat_d   = HB;
         vb_lat_d   = VB;
         state_d    = StAddr;
      end
   end

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         state_q     <= StIdle;
         pal_addr_q  <= '0;
         hb_lat_q    <= 1'b0;
         vb_lat_q    <= 1'b0;
         pal_q       <= '0;
         b_lat_q     <= 5'd16;
         last_vb_q   <= 1'b0;
         red_q       <= 8'd0;
         green_q     <= 8'd0;
         blue_q      <= 8'd0;
         hb_out_q    <= 1'b1;
         vb_out_q    <= 1'b1;
         pix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pal_addr_q  <= pal_addr_d;
         hb_lat_q    <= hb_lat_d;
         vb_lat_q    <= vb_lat_d;
         pal_q       <= pal_d;
         b_lat_q     <= b_lat_d;
         last_vb_q   <= VB;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         hb_out_q    <= hb_out_d;
         vb_out_q    <= vb_out_d;
         pix_valid_q <= pix_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign PAL_ADDR  = pal_addr_q;
   assign RED       = red_q;
   assign GREEN     = green_q;
   assign BLUE      = blue_q;
   assign HB_OUT    = hb_out_q;
   assign VB_OUT    = vb_out_q;
   assign PIX_VALID = pix_valid_q;
   assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_garegga_colmix.sv
// Self-checking bench for garegga_colmix: table of single-pixel vectors plus hand-written
// sequences for back-to-back, overrun and mid-sequence reset. The palette RAM is modelled
// as a registered-read array.
module tb_garegga_colmix;

   logic        CLK96 = 1'b0;
   logic        RESET96 = 1'b1;
   logic        PIXEL_CEN = 1'b0;
   logic        HB = 1'b0;
   logic        VB = 1'b0;
   logic [10:0] TEXT_PIXEL = '0;
   logic [10:0] GP_PIXEL = '0;
   logic [4:0]  BRIGHT = 5'd16;
   logic [10:0] PAL_ADDR;
   logic [15:0] PAL_DATA = '0;
   logic [7:0]  RED, GREEN, BLUE;
   logic        HB_OUT, VB_OUT, PIX_VALID, OVERRUN;

   logic [15:0] pal_mem [2048];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 CLK96 = ~CLK96;

   always @(posedge CLK96) PAL_DATA <= pal_mem[PAL_ADDR];

   garegga_colmix #(.PAL_AW(11)) dut (
      .CLK96      (CLK96),
      .RESET96    (RESET96),
      .PIXEL_CEN  (PIXEL_CEN),
      .HB         (HB),
      .VB         (VB),
      .TEXT_PIXEL (TEXT_PIXEL),
      .GP_PIXEL   (GP_PIXEL),
      .BRIGHT     (BRIGHT),
      .PAL_ADDR   (PAL_ADDR),
      .PAL_DATA   (PAL_DATA),
      .RED        (RED),
      .GREEN      (GREEN),
      .BLUE       (BLUE),
      .HB_OUT     (HB_OUT),
      .VB_OUT     (VB_OUT),
      .PIX_VALID  (PIX_VALID),
      .OVERRUN    (OVERRUN)
   );

   typedef struct {
      logic [10:0] text;
      logic [10:0] gp;
      logic        hb;
      logic        vb;
      logic [4:0]  bright;
      logic [15:0] pal;
      logic [10:0] exp_addr;
      logic [23:0] exp_rgb;
      logic        exp_hb;
      logic        exp_vb;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK96);
      #1;
   endtask

   // Drive one pixel enable; returns just after edge N.
   task automatic issue(input logic [10:0] text, input logic [10:0] gp, input logic hb,
                        input logic vb);
      @(negedge CLK96);
      TEXT_PIXEL = text;
      GP_PIXEL   = gp;
      HB         = hb;
      VB         = vb;
      PIXEL_CEN  = 1'b1;
      tick();
      @(negedge CLK96);
      PIXEL_CEN = 1'b0;
      HB        = 1'b0;
      VB        = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      BRIGHT = v.bright;
      pal_mem[v.exp_addr] = v.pal;
      @(negedge CLK96);
      TEXT_PIXEL = v.text;
      GP_PIXEL   = v.gp;
      HB         = v.hb;
      VB         = v.vb;
      PIXEL_CEN  = 1'b1;
      tick();                                            // N
      check($sformatf("v%0d pal_addr", idx), 32'(PAL_ADDR), 32'(v.exp_addr));
      @(negedge CLK96);
      PIXEL_CEN = 1'b0;
      HB        = 1'b0;
      VB        = 1'b0;
      tick();                                            // N+1
      tick();                                            // N+2
      check($sformatf("v%0d early valid", idx), 32'(PIX_VALID), 32'd0);
      tick();                                            // N+3
      check($sformatf("v%0d valid", idx), 32'(PIX_VALID), 32'd1);
      check($sformatf("v%0d rgb", idx), 32'({RED, GREEN, BLUE}), 32'(v.exp_rgb));
      check($sformatf("v%0d blanks", idx), 32'({HB_OUT, VB_OUT}), 32'({v.exp_hb, v.exp_vb}));
      tick();                                            // N+4
      check($sformatf("v%0d valid drop", idx), 32'(PIX_VALID), 32'd0);
      check($sformatf("v%0d overrun", idx), 32'(OVERRUN), 32'd0);
      tick();
   endtask

   initial begin
      int bad_valid;
      vec_t v;

      //          text    gp      hb   vb   bri    pal       addr    rgb           hbo  vbo
      vecs[0]  = '{11'h412, 11'h235, 1'b0, 1'b0, 5'd16, 16'h7FFF, 11'h412, 24'hFFFFFF, 1'b0, 1'b0};
      vecs[1]  = '{11'h410, 11'h235, 1'b0, 1'b0, 5'd16, 16'h0210, 11'h235, 24'h848400, 1'b0, 1'b0};
      vecs[2]  = '{11'h400, 11'h230, 1'b0, 1'b0, 5'd16, 16'h001F, 11'h000, 24'hFF0000, 1'b0, 1'b0};
      vecs[3]  = '{11'h000, 11'h7F1, 1'b0, 1'b0, 5'd16, 16'h7C00, 11'h7F1, 24'h0000FF, 1'b0, 1'b0};
      // BRIGHT=8 mid-frame: still full brightness.
      vecs[4]  = '{11'h123, 11'h000, 1'b0, 1'b0, 5'd8,  16'h7FFF, 11'h123, 24'hFFFFFF, 1'b0, 1'b0};
      // VB rise together with the pixel: latches 8, pixel blanked.
      vecs[5]  = '{11'h005, 11'h000, 1'b0, 1'b1, 5'd8,  16'h7FFF, 11'h005, 24'h000000, 1'b0, 1'b1};
      vecs[6]  = '{11'h412, 11'h235, 1'b0, 1'b0, 5'd8,  16'h7FFF, 11'h412, 24'h7F7F7F, 1'b0, 1'b0};
      vecs[7]  = '{11'h010, 11'h235, 1'b0, 1'b0, 5'd8,  16'h0210, 11'h235, 24'h424200, 1'b0, 1'b0};
      vecs[8]  = '{11'h412, 11'h000, 1'b1, 1'b0, 5'd31, 16'h7FFF, 11'h412, 24'h000000, 1'b1, 1'b0};
      vecs[9]  = '{11'h000, 11'h000, 1'b0, 1'b1, 5'd31, 16'h7FFF, 11'h000, 24'h000000, 1'b0, 1'b1};
      vecs[10] = '{11'h412, 11'h000, 1'b0, 1'b0, 5'd31, 16'h7FFF, 11'h412, 24'hFFFFFF, 1'b0, 1'b0};
      vecs[11] = '{11'h000, 11'h000, 1'b0, 1'b1, 5'd0,  16'h7FFF, 11'h000, 24'h000000, 1'b0, 1'b1};
      vecs[12] = '{11'h412, 11'h000, 1'b0, 1'b0, 5'd0,  16'h7FFF, 11'h412, 24'h000000, 1'b0, 1'b0};
      vecs[13] = '{11'h000, 11'h000, 1'b0, 1'b1, 5'd31, 16'h0000, 11'h000, 24'h000000, 1'b0, 1'b1};
      vecs[14] = '{11'h7A1, 11'h3C2, 1'b0, 1'b0, 5'd31, 16'h0421, 11'h7A1, 24'h080808, 1'b0, 1'b0};

      for (int i = 0; i < 2048; i++) pal_mem[i] = 16'h0000;

      // Reset state.
      repeat (3) @(posedge CLK96);
      #1;
      check("reset rgb", 32'({RED, GREEN, BLUE}), 32'd0);
      check("reset blanks", 32'({HB_OUT, VB_OUT}), 32'b11);
      check("reset valid", 32'(PIX_VALID), 32'd0);
      check("reset overrun", 32'(OVERRUN), 32'd0);
      check("reset pal_addr", 32'(PAL_ADDR), 32'd0);
      @(negedge CLK96);
      RESET96 = 1'b0;
      repeat (2) @(negedge CLK96);

      for (int i = 0; i < 15; i++) begin
         v = vecs[i];
         run_vec(v, i);
      end

      // Back-to-back: second pixel at N+3 is accepted without overrun.
      BRIGHT = 5'd16;
      pal_mem[11'h412] = 16'h7FFF;
      pal_mem[11'h235] = 16'h0210;
      issue(11'h412, 11'h000, 1'b0, 1'b0);               // N, now between N and N+1
      tick();                                            // N+1
      tick();                                            // N+2
      @(negedge CLK96);
      TEXT_PIXEL = 11'h000;
      GP_PIXEL   = 11'h235;
      PIXEL_CEN  = 1'b1;
      tick();                                            // N+3 = N'
      check("b2b first rgb", 32'({RED, GREEN, BLUE}), 32'hFFFFFF);
      check("b2b first valid", 32'(PIX_VALID), 32'd1);
      check("b2b pal_addr", 32'(PAL_ADDR), 32'h235);
      check("b2b no overrun", 32'(OVERRUN), 32'd0);
      @(negedge CLK96);
      PIXEL_CEN = 1'b0;
      tick();                                            // N'+1
      tick();                                            // N'+2
      check("b2b gap valid", 32'(PIX_VALID), 32'd0);
      tick();                                            // N'+3
      check("b2b second rgb", 32'({RED, GREEN, BLUE}), 32'h848400);
      check("b2b second valid", 32'(PIX_VALID), 32'd1);
      repeat (3) tick();

      // Overrun: second pixel at N+2.
      issue(11'h412, 11'h000, 1'b0, 1'b0);               // N
      tick();                                            // N+1
      @(negedge CLK96);
      TEXT_PIXEL = 11'h000;
      GP_PIXEL   = 11'h235;
      PIXEL_CEN  = 1'b1;
      tick();                                            // N+2 = N'
      check("ovr flag", 32'(OVERRUN), 32'd1);
      check("ovr pal_addr", 32'(PAL_ADDR), 32'h235);
      @(negedge CLK96);
      PIXEL_CEN = 1'b0;
      tick();                                            // N+3
      check("ovr no valid at N+3", 32'(PIX_VALID), 32'd0);
      check("ovr rgb held", 32'({RED, GREEN, BLUE}), 32'h848400);
      tick();                                            // N'+2
      check("ovr no valid at N'+2", 32'(PIX_VALID), 32'd0);
      tick();                                            // N'+3
      check("ovr second valid", 32'(PIX_VALID), 32'd1);
      check("ovr second rgb", 32'({RED, GREEN, BLUE}), 32'h848400);
      repeat (6) tick();
      check("ovr sticky", 32'(OVERRUN), 32'd1);

      // Put a non-default brightness in b_lat so the reset value is observable.
      BRIGHT = 5'd4;
      @(negedge CLK96);
      VB = 1'b1;
      @(negedge CLK96);
      VB = 1'b0;
      repeat (2) @(negedge CLK96);

      // Reset mid-sequence.
      issue(11'h412, 11'h000, 1'b0, 1'b0);               // N
      @(posedge CLK96);                                  // N+1
      #1;
      RESET96 = 1'b1;
      #1;
      check("midrst rgb", 32'({RED, GREEN, BLUE}), 32'd0);
      check("midrst blanks", 32'({HB_OUT, VB_OUT}), 32'b11);
      check("midrst overrun", 32'(OVERRUN), 32'd0);
      check("midrst pal_addr", 32'(PAL_ADDR), 32'd0);
      bad_valid = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (PIX_VALID !== 1'b0) bad_valid++;
      end
      @(negedge CLK96);
      RESET96 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (PIX_VALID !== 1'b0) bad_valid++;
      end
      check("midrst no valid", 32'(bad_valid), 32'd0);

      // After reset: colour-path pixel at full brightness despite BRIGHT=4.
      v = '{11'h412, 11'h235, 1'b0, 1'b0, 5'd4, 16'h7FFF, 11'h412, 24'hFFFFFF, 1'b0, 1'b0};
      run_vec(v, 99);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
